// File: rtl/dualport_ram_pkg.sv
// Shared definitions for the dualport_ram stream reader: FSM encoding and
// sizing helpers for the output buffer.
package dualport_ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  // Minimum bit width able to index `value` distinct items; never below 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_out_fifo.sv
// Small synchronous FIFO holding {last, data} beats for the stream output.
// The head entry is presented combinationally; depth need not be a power of 2.
module stream_out_fifo
  import dualport_ram_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 3,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/dualport_ram_stream_reader.sv
// Streams a (start address, length) range out of a dualport_ram read port as
// an AXI-Stream master, hiding the RAM read latency behind a small buffer.
module dualport_ram_stream_reader
  import dualport_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [ADDR_WIDTH:0]   CMD_LEN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int CNT_W     = clog2(BUF_DEPTH + 1);
  localparam int LEN_W     = ADDR_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    iss_q, iss_d;
  logic                    iss_last_q, iss_last_d;
  logic [RD_LATENCY-1:0]   vld_sr_q, vld_sr_d;
  logic [RD_LATENCY-1:0]   last_sr_q, last_sr_d;
  logic [CNT_W-1:0]        infl_q, infl_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        occ;
  logic [DATA_WIDTH:0]     head;
  logic [CNT_W:0]          used;
  logic                    push, pop, credit;

  assign push = vld_sr_q[RD_LATENCY-1];
  assign pop  = (occ != '0) && M_AXIS_TREADY;
  assign used = {1'b0, occ} + {1'b0, infl_q};
  // A slot freed by this cycle's pop is reusable at once; without that the
  // buffer would need one more entry to sustain a beat every cycle.
  assign credit = (used < (CNT_W + 1)'(BUF_DEPTH)) || pop;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    iss_d      = 1'b0;
    iss_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          if (CMD_LEN == '0) begin
            state_d = FINISH;
          end else begin
            iss_d      = 1'b1;
            iss_last_d = (CMD_LEN == LEN_W'(1));
            addr_d     = CMD_ADDR;
            rem_d      = CMD_LEN - LEN_W'(1);
            state_d    = (CMD_LEN == LEN_W'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          iss_d      = 1'b1;
          iss_last_d = (rem_q == LEN_W'(1));
          addr_d     = addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == '0 && (occ == '0 || (occ == CNT_W'(1) && pop))) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // iss_q marks the cycle an address sits on the RAM; the shift register
    // then follows that read until its data is captured.
    vld_sr_d    = (vld_sr_q << 1) | RD_LATENCY'(iss_q);
    last_sr_d   = (last_sr_q << 1) | RD_LATENCY'(iss_last_q);
    infl_d      = infl_q + CNT_W'(iss_d) - CNT_W'(push);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      iss_q       <= 1'b0;
      iss_last_q  <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      infl_q      <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      iss_q       <= iss_d;
      iss_last_q  <= iss_last_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      infl_q      <= infl_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  stream_out_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst      (ARESET),
    .push     (push),
    .push_data({last_sr_q[RD_LATENCY-1], RAM_R_DATA}),
    .pop      (pop),
    .head_data(head),
    .count    (occ)
  );

  assign CMD_READY     = cmd_ready_q;
  assign RAM_R_ADDR    = addr_q;
  assign M_AXIS_TVALID = (occ != '0);
  assign M_AXIS_TDATA  = head[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = (occ != '0) && head[DATA_WIDTH];
  assign BUSY          = busy_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_dualport_ram_stream_reader.sv
// Directed bench for dualport_ram_stream_reader with a behavioural 1-cycle RAM
// and a scoreboard queue of expected {last, data} beats.
module tb_dualport_ram_stream_reader;

  logic       clk = 1'b0;
  logic       areset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [4:0] cmd_len;
  logic [3:0] ram_r_addr;
  logic [7:0] ram_r_data;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  logic [8:0] exp_q [$];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  always #5 clk = ~clk;

  // Read port of the RAM: one cycle from address to data.
  always @(posedge clk) ram_r_data <= mem[ram_r_addr];

  dualport_ram_stream_reader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .RD_LATENCY(1)
  ) dut (
    .ACLK         (clk),
    .ARESET       (areset),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_ADDR     (cmd_addr),
    .CMD_LEN      (cmd_len),
    .RAM_R_ADDR   (ram_r_addr),
    .RAM_R_DATA   (ram_r_data),
    .M_AXIS_TDATA (tdata),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST (tlast),
    .BUSY         (busy),
    .DONE         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command in the current cycle (cycle 0); returns in cycle 1.
  task automatic apply_cmd(input string name, input logic [3:0] a, input logic [4:0] l);
    check({name, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(name, done, 1);
  endtask

  // Monitor: scoreboard pops on every handshake and stall stability checks.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_beat;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid_held", tvalid, 1);
          check("stall_beat_stable", {tlast, tdata}, prev_beat);
        end
        if (done) done_cnt++;
        if (tvalid && tready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected actual=%0h required=no_beat", {tlast, tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat", {tlast, tdata}, e);
          end
        end
        prev_stall = tvalid && !tready;
        prev_beat  = {tlast, tdata};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, bad, max_out, outst;
    logic seen;
    logic [3:0] wrap_addr [4];
    wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1};

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);
    areset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; tready = 1'b1;

    // Reset state
    step(2);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_addr", ram_r_addr, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    areset = 1'b0;
    step(1);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Single word, exact timing
    mem[1] = 8'hCA;
    d0 = done_cnt;
    exp_q.push_back({1'b1, 8'hCA});
    apply_cmd("t1", 4'd1, 5'd1);
    check("t1_c1_ram_addr", ram_r_addr, 1);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_cmd_ready", cmd_ready, 0);
    step(1);
    check("t1_c2_tvalid", tvalid, 0);
    step(1);
    check("t1_c3_tvalid", tvalid, 1);
    check("t1_c3_tlast", tlast, 1);
    check("t1_c3_tdata", tdata, 8'hCA);
    step(1);
    check("t1_c4_done", done, 1);
    check("t1_c4_busy", busy, 0);
    check("t1_c4_tvalid", tvalid, 0);
    step(1);
    check("t1_c5_done", done, 0);
    check("t1_c5_cmd_ready", cmd_ready, 1);
    check("t1_done_count", done_cnt - d0, 1);
    mem[1] = 8'h11;

    // Full RAM, back-to-back
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(i * 8'h11)});
    apply_cmd("t2", 4'd0, 5'd16);
    bad = 0;
    for (int c = 1; c <= 19; c++) begin
      if (tvalid !== (c >= 3 && c <= 18)) bad++;
      if (tvalid === 1'b1 && tlast !== (c == 18)) bad++;
      if (done !== (c == 19)) bad++;
      step(1);
    end
    check("t2_window_errors", bad, 0);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Address wrap
    d0 = done_cnt;
    exp_q.push_back({1'b0, 8'hEE});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h11});
    apply_cmd("t3", 4'd14, 5'd4);
    for (int c = 0; c < 4; c++) begin
      check("t3_ram_addr", ram_r_addr, wrap_addr[c]);
      step(1);
    end
    wait_done("t3_done", 20);
    step(1);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Backpressure
    d0 = done_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(i * 8'h11)});
    apply_cmd("t4", 4'd0, 5'd8);
    max_out = 0;
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      tready = (c < 4) ? 1'b1 : (c <= 9) ? 1'b0 : ((c % 2) == 0);
      outst = int'(ram_r_addr) + 1 - (acc_cnt - a0);
      if (outst > max_out) max_out = outst;
      if (done === 1'b1) seen = 1'b1;
      step(1);
    end
    tready = 1'b1;
    check("t4_done_seen", seen, 1);
    check("t4_max_outstanding", max_out, 3);
    check("t4_beats_accepted", acc_cnt - a0, 8);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_queue_empty", exp_q.size(), 0);

    // Zero length
    d0 = done_cnt;
    apply_cmd("t5", 4'd5, 5'd0);
    check("t5_c1_done", done, 1);
    check("t5_c1_cmd_ready", cmd_ready, 0);
    check("t5_c1_tvalid", tvalid, 0);
    check("t5_c1_busy", busy, 0);
    step(1);
    check("t5_c2_done", done, 0);
    check("t5_c2_cmd_ready", cmd_ready, 1);
    check("t5_done_count", done_cnt - d0, 1);

    // Reset mid-burst, then a fresh command
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h11});
    apply_cmd("t6a", 4'd0, 5'd8);
    step(4);
    areset = 1'b1;
    step(1);
    areset = 1'b0;
    check("t6_tvalid", tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_cmd_ready_low", cmd_ready, 0);
    check("t6_ram_addr", ram_r_addr, 0);
    check("t6_queue_drained", exp_q.size(), 0);
    step(1);
    check("t6_cmd_ready_back", cmd_ready, 1);
    d0 = done_cnt;
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    apply_cmd("t6b", 4'd2, 5'd2);
    wait_done("t6_done_pulse", 20);
    step(1);
    check("t6_done_count", done_cnt - d0, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
